// File: rtl/gnn_example_weight.sv
// gnn_example_weight: weight-load engine of the GNN accelerator.
//
// Takes one 96-bit weight-load instruction per ap_start and issues a single
// DRAM read request to the external AXI read master. It packs the returned
// 512-bit beats 16 at a time into 8192-bit weight-buffer lines, writes those
// lines to consecutive buffer addresses, and then pulses ap_done.
//
// Instruction fields:
//   [95:80] SIZE      bytes to load (SIZE mod 64 is dropped)
//   [79:64] DRAM_OFS  offset from ctrl_addr_offset, in 64-byte units
//   [63:48] LINES     informational only
//   [47:32] BUF_ADDR  first buffer line; only the low 13 bits are used
//   [31:0]  reserved
//
// Ports:
//   kernel_clk, kernel_rst            clock, synchronous active-high reset
//   ap_start / ap_done                instruction strobe / completion pulse
//   ctrl_addr_offset, ctrl_instruction   DRAM base address, instruction
//   dram_xfer_start_addr, dram_xfer_size_in_bytes, read_start   read request
//   read_done                         not used for control
//   data_tvalid/tready/tlast/tdata    read stream (tlast is ignored)
//   weight_write_buffer_w_*           weight-buffer line write port
//   perf_busy_cycles                  only when WEIGHT_PERF_CNT_EN is defined
//
// Optional feature macro: WEIGHT_PERF_CNT_EN. When it is defined, a counter
// of busy (non-IDLE) cycles is added. It is cleared on every accepted
// ap_start.
//
// state | meaning
// IDLE  | waiting for ap_start, stream not ready
// ISSUE | read_start pulse, beat counter loaded
// RECV  | accepting beats and writing each line once it is full
// FLUSH | final line write cycle
// DONE  | ap_done pulse
module gnn_example_weight #(
  parameter int WEIGHT_INST_LENGTH = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32
) (
  input  logic                              kernel_clk,
  input  logic                              kernel_rst,
  input  logic                              ap_start,
  output logic                              ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     ctrl_addr_offset,
  input  logic [WEIGHT_INST_LENGTH-1:0]     ctrl_instruction,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     dram_xfer_start_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]      dram_xfer_size_in_bytes,
  output logic                              read_start,
  input  logic                              read_done,
  input  logic                              data_tvalid,
  output logic                              data_tready,
  input  logic                              data_tlast,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     data_tdata,
  output logic                              weight_write_buffer_w_valid,
  output logic [12:0]                       weight_write_buffer_w_addr,
  output logic [16*C_M_AXI_DATA_WIDTH-1:0]  weight_write_buffer_w_data
`ifdef WEIGHT_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_busy_cycles
`endif
);

  localparam int LINE_W = 16 * C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_RECV  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   xfer_addr_q, xfer_addr_d;
  logic [C_XFER_SIZE_WIDTH-1:0]    xfer_size_q, xfer_size_d;
  logic [12:0]                     buf_addr_q, buf_addr_d;
  logic [C_ADDER_BIT_WIDTH-1:0]    beats_left_q, beats_left_d;
  logic [C_ADDER_BIT_WIDTH-1:0]    line_idx_q, line_idx_d;
  logic [3:0]                      slot_q, slot_d;
  logic [LINE_W-1:0]               line_q, line_d;
  logic [LINE_W-1:0]               line_ins;
  logic                            w_valid_q, w_valid_d;
  logic [12:0]                     w_addr_q, w_addr_d;
  logic [LINE_W-1:0]               w_data_q, w_data_d;
  logic                            line_full;
  logic                            last_beat;

  always_comb begin
    state_d      = state_q;
    xfer_addr_d  = xfer_addr_q;
    xfer_size_d  = xfer_size_q;
    buf_addr_d   = buf_addr_q;
    beats_left_d = beats_left_q;
    line_idx_d   = line_idx_q;
    slot_d       = slot_q;
    line_d       = line_q;
    w_valid_d    = 1'b0;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;

    // Current line with the incoming beat dropped into its slot. The slot
    // times 512 is written as a concatenation with nine zero bits.
    line_ins = line_q;
    line_ins[{slot_q, 9'd0} +: C_M_AXI_DATA_WIDTH] = data_tdata;
    line_full = (slot_q == 4'd15);
    last_beat = (beats_left_q == C_ADDER_BIT_WIDTH'(1));

    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          xfer_addr_d = ctrl_addr_offset +
                        (C_M_AXI_ADDR_WIDTH'(ctrl_instruction[79:64]) << 6);
          xfer_size_d = C_XFER_SIZE_WIDTH'(ctrl_instruction[95:80]);
          buf_addr_d  = ctrl_instruction[44:32];
          line_idx_d  = '0;
          slot_d      = '0;
          line_d      = '0;
          state_d     = (ctrl_instruction[95:80] == 16'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        beats_left_d = C_ADDER_BIT_WIDTH'(xfer_size_q >> 6);
        // A load smaller than one beat still issues the read, but there is
        // nothing to wait for.
        state_d = ((xfer_size_q >> 6) == '0) ? S_DONE : S_RECV;
      end
      S_RECV: begin
        if (data_tvalid) begin
          beats_left_d = beats_left_q - C_ADDER_BIT_WIDTH'(1);
          if (line_full || last_beat) begin
            w_valid_d  = 1'b1;
            w_addr_d   = buf_addr_q + line_idx_q[12:0];
            w_data_d   = line_ins;
            line_idx_d = line_idx_q + C_ADDER_BIT_WIDTH'(1);
            slot_d     = '0;
            line_d     = '0;
            if (last_beat) state_d = S_FLUSH;
          end else begin
            slot_d = slot_q + 4'd1;
            line_d = line_ins;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      state_q      <= S_IDLE;
      xfer_addr_q  <= '0;
      xfer_size_q  <= '0;
      buf_addr_q   <= '0;
      beats_left_q <= '0;
      line_idx_q   <= '0;
      slot_q       <= '0;
      line_q       <= '0;
      w_valid_q    <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      xfer_addr_q  <= xfer_addr_d;
      xfer_size_q  <= xfer_size_d;
      buf_addr_q   <= buf_addr_d;
      beats_left_q <= beats_left_d;
      line_idx_q   <= line_idx_d;
      slot_q       <= slot_d;
      line_q       <= line_d;
      w_valid_q    <= w_valid_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
    end
  end

  assign read_start                  = (state_q == S_ISSUE);
  assign data_tready                 = (state_q == S_RECV);
  assign ap_done                     = (state_q == S_DONE);
  assign dram_xfer_start_addr        = xfer_addr_q;
  assign dram_xfer_size_in_bytes     = xfer_size_q;
  assign weight_write_buffer_w_valid = w_valid_q;
  assign weight_write_buffer_w_addr  = w_addr_q;
  assign weight_write_buffer_w_data  = w_data_q;

`ifdef WEIGHT_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (ap_start) perf_d = '0;
    end else begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) perf_q <= '0;
    else            perf_q <= perf_d;
  end

  assign perf_busy_cycles = perf_q;
`endif

  // Inputs and counter bits that carry no control meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{read_done, data_tlast, ctrl_instruction[63:45],
                           ctrl_instruction[31:0],
                           line_idx_q[C_ADDER_BIT_WIDTH-1:13]};

endmodule

// File: tb/tb_gnn_example_weight.sv
module tb_gnn_example_weight;
  localparam int LW = 8192;

  logic            kernel_clk = 1'b0;
  logic            kernel_rst = 1'b1;
  logic            ap_start = 1'b0;
  logic            ap_done;
  logic [63:0]     ctrl_addr_offset = '0;
  logic [95:0]     ctrl_instruction = '0;
  logic [63:0]     dram_xfer_start_addr;
  logic [31:0]     dram_xfer_size_in_bytes;
  logic            read_start;
  logic            read_done = 1'b0;
  logic            data_tvalid = 1'b0;
  logic            data_tready;
  logic            data_tlast = 1'b0;
  logic [511:0]    data_tdata = '0;
  logic            w_valid;
  logic [12:0]     w_addr;
  logic [LW-1:0]   w_data;
`ifdef WEIGHT_PERF_CNT_EN
  logic [31:0]     perf_busy_cycles;
`endif

  always #5 kernel_clk = ~kernel_clk;

  gnn_example_weight dut (
    .kernel_clk(kernel_clk), .kernel_rst(kernel_rst),
    .ap_start(ap_start), .ap_done(ap_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
    .dram_xfer_start_addr(dram_xfer_start_addr),
    .dram_xfer_size_in_bytes(dram_xfer_size_in_bytes),
    .read_start(read_start), .read_done(read_done),
    .data_tvalid(data_tvalid), .data_tready(data_tready),
    .data_tlast(data_tlast), .data_tdata(data_tdata),
    .weight_write_buffer_w_valid(w_valid),
    .weight_write_buffer_w_addr(w_addr),
    .weight_write_buffer_w_data(w_data)
`ifdef WEIGHT_PERF_CNT_EN
    , .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  int cyc = 0;
  always @(posedge kernel_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: expected line writes (address, contents, cycle), and the
  // cycles at which read_start and ap_done must appear.
  typedef struct {
    logic [12:0]   addr;
    logic [LW-1:0] data;
    int            cyc;
  } wr_t;
  wr_t           exp_q[$];
  int            exp_rs_cyc = -1;
  int            exp_done_cyc = -1;
  logic [63:0]   exp_rs_addr = '0;
  logic [31:0]   exp_rs_size = '0;

  int            n_rs = 0, n_wr = 0, n_done = 0;
  logic [63:0]   last_rs_addr = '0;
  logic [31:0]   last_rs_size = '0;
  logic [LW-1:0] wlog_data[$];
  logic [12:0]   wlog_addr[$];

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    int s;
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      s = 0;
      for (int k = 15; k >= 0; k--)
        if (act[k*512 +: 512] !== exp[k*512 +: 512]) s = k;
      $display("FAIL %s slot %0d: got %0h expected %0h (low 64 bits)", name, s,
               act[s*512 +: 64], exp[s*512 +: 64]);
    end
  endtask

  // Compare process: every cycle out of reset, the three strobes are checked
  // against the model, along with the payload of any strobe that fires.
  always @(negedge kernel_clk) begin
    bit ev_w;
    if (!kernel_rst) begin
      ev_w = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk64("w_valid", 64'(w_valid), 64'(ev_w));
      if (w_valid) begin
        n_wr++;
        wlog_data.push_back(w_data);
        wlog_addr.push_back(w_addr);
      end
      if (ev_w) begin
        if (w_valid) begin
          chk64("w_addr", 64'(w_addr), 64'(exp_q[0].addr));
          chk_line("w_data", w_data, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end
      chk64("read_start", 64'(read_start), 64'(cyc == exp_rs_cyc));
      if (read_start) begin
        n_rs++;
        last_rs_addr = dram_xfer_start_addr;
        last_rs_size = dram_xfer_size_in_bytes;
        chk64("rs_addr", dram_xfer_start_addr, exp_rs_addr);
        chk64("rs_size", 64'(dram_xfer_size_in_bytes), 64'(exp_rs_size));
      end
      chk64("ap_done", 64'(ap_done), 64'(cyc == exp_done_cyc));
      if (ap_done) n_done++;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk64({tag, "_ap_done"}, 64'(ap_done), 64'd0);
    chk64({tag, "_read_start"}, 64'(read_start), 64'd0);
    chk64({tag, "_tready"}, 64'(data_tready), 64'd0);
    chk64({tag, "_w_valid"}, 64'(w_valid), 64'd0);
    chk64({tag, "_w_addr"}, 64'(w_addr), 64'd0);
    chk64({tag, "_w_data"}, 64'(|w_data), 64'd0);
    chk64({tag, "_addr"}, dram_xfer_start_addr, 64'd0);
    chk64({tag, "_size"}, 64'(dram_xfer_size_in_bytes), 64'd0);
  endtask

  // Issues one instruction and supplies the stream. Beat i (0-based) of an
  // n-beat load carries the value n-i. The model groups beats 16 to a line and
  // sets each write one cycle after the beat that closes its line.
  task automatic run_load(input int size, input int ofs, input int bufa,
                          input logic [63:0] offset, input bit gaps,
                          input int mid_start_at, input int rst_at);
    int nb, i, guard, n_rs0, n_wr0, n_done0;
    logic [LW-1:0]  line;
    logic [511:0]   beat;
    logic [15:0]    sz16, ofs16, ln16, buf16;
    nb = size >> 6;
    sz16 = 16'(size); ofs16 = 16'(ofs); ln16 = 16'((size + 1023) / 1024); buf16 = 16'(bufa);
    wlog_data.delete();
    wlog_addr.delete();
    @(negedge kernel_clk);
    n_rs0 = n_rs; n_wr0 = n_wr; n_done0 = n_done;
    ap_start = 1'b1;
    ctrl_instruction = {sz16, ofs16, ln16, buf16, 32'h0};
    ctrl_addr_offset = offset;
    exp_rs_addr = offset + (64'(ofs) * 64);
    exp_rs_size = 32'(size);
    if (size == 0) exp_done_cyc = cyc + 1;
    else exp_rs_cyc = cyc + 1;
    @(negedge kernel_clk);
    ap_start = 1'b0;
    ctrl_instruction = '1;
    ctrl_addr_offset = '1;
    line = '0;
    i = 0;
    guard = 0;
    while (i < nb && guard < 4000) begin
      if (rst_at >= 0 && i == rst_at) break;
      data_tvalid = 1'b0;
      data_tlast = 1'b0;
      ap_start = (mid_start_at >= 0 && i == mid_start_at);
      if (data_tready && !(gaps && (guard % 4 == 1))) begin
        beat = 512'(nb - i);
        data_tvalid = 1'b1;
        data_tdata = beat;
        data_tlast = (i == nb - 1);
        line[(i % 16) * 512 +: 512] = beat;
        if ((i % 16 == 15) || (i == nb - 1)) begin
          exp_q.push_back('{13'(bufa + i / 16), line, cyc + 1});
          line = '0;
        end
        if (i == nb - 1) exp_done_cyc = cyc + 2;
        i++;
      end
      guard++;
      @(negedge kernel_clk);
    end
    if (guard >= 4000) begin
      n_cmp++; n_fail++;
      $display("FAIL stream_timeout: got %0d beats expected %0d", i, nb);
    end
    if (rst_at >= 0) begin
      kernel_rst = 1'b1;
      @(negedge kernel_clk);
      chk_all_zero("rst_mid");
      kernel_rst = 1'b0;
      data_tvalid = 1'b1;
      data_tdata = 512'hdead;
      repeat (6) @(negedge kernel_clk);
      chk64("rst_tready_low", 64'(data_tready), 64'd0);
      data_tvalid = 1'b0;
      chk64("rst_done_cnt", 64'(n_done - n_done0), 64'd0);
      chk64("rst_wr_cnt", 64'(n_wr - n_wr0), 64'd1);
    end else begin
      data_tvalid = 1'b0;
      ap_start = 1'b0;
      data_tlast = 1'b0;
      repeat (3) @(negedge kernel_clk);
      chk64("done_cnt", 64'(n_done - n_done0), 64'd1);
      chk64("rs_cnt", 64'(n_rs - n_rs0), 64'(size != 0));
      chk64("wr_cnt", 64'(n_wr - n_wr0), 64'((nb + 15) / 16));
    end
    chk64("pending_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge kernel_clk);
    chk_all_zero("reset");
    kernel_rst = 1'b0;
    repeat (2) @(negedge kernel_clk);

    // One full line, from 16 beats valued 16 down to 1.
    run_load(1024, 0, 0, 64'h0, 1'b0, -1, -1);
    chk64("t1_rs_addr", last_rs_addr, 64'h0);
    chk64("t1_rs_size", 64'(last_rs_size), 64'd1024);
    chk64("t1_nwr", 64'(wlog_data.size()), 64'd1);
    if (wlog_data.size() == 1) begin
      chk64("t1_addr", 64'(wlog_addr[0]), 64'd0);
      chk64("t1_slot0", 64'(wlog_data[0][511:0]), 64'd16);
      chk64("t1_slot15", 64'(wlog_data[0][8191:7680]), 64'd1);
    end

    // 160 beats forming ten lines at 12..21, with a stray ap_start mid-stream.
    run_load(10240, 0, 12, 64'h0, 1'b0, 40, -1);
    chk64("t2_nwr", 64'(wlog_data.size()), 64'd10);
    if (wlog_data.size() == 10) begin
      chk64("t2_addr_first", 64'(wlog_addr[0]), 64'd12);
      chk64("t2_addr_last", 64'(wlog_addr[9]), 64'd21);
      chk64("t2_first_beat", 64'(wlog_data[0][511:0]), 64'd160);
      chk64("t2_last_beat", 64'(wlog_data[9][8191:7680]), 64'd1);
    end

    // Base offset plus DRAM_OFS, with gaps in tvalid.
    run_load(2048, 2, 300, 64'h1000, 1'b1, -1, -1);
    chk64("t3_rs_addr", last_rs_addr, 64'h1080);
    if (wlog_addr.size() == 2) begin
      chk64("t3_addr0", 64'(wlog_addr[0]), 64'd300);
      chk64("t3_addr1", 64'(wlog_addr[1]), 64'd301);
    end

    // 17 beats give a partial second line, and the buffer address wraps.
    run_load(1088, 0, 8191, 64'h0, 1'b0, -1, -1);
    if (wlog_data.size() == 2) begin
      chk64("t4_addr1_wrap", 64'(wlog_addr[1]), 64'd0);
      chk64("t4_l1_slot0", 64'(wlog_data[1][511:0]), 64'd1);
      chk64("t4_l1_rest_zero", 64'(|wlog_data[1][8191:512]), 64'd0);
    end

    // A zero-size instruction completes at once, with no read and no write.
    run_load(0, 0, 7, 64'h0, 1'b0, -1, -1);

    // Reset after 20 beats of a two-line load, then a normal load.
    run_load(2048, 0, 100, 64'h0, 1'b0, -1, 20);
    run_load(1024, 0, 5, 64'h0, 1'b0, -1, -1);
    if (wlog_addr.size() == 1) chk64("t7_addr", 64'(wlog_addr[0]), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end
endmodule
